// File: rtl/cl_note_queue_bank.sv
// cl_note_queue_bank: per-pitch bank of note-timestamp queues.
// Song words are loaded once (LOAD). After the end marker the lane logic pops
// each channel independently (PLAY). restart rewinds every read index so the
// song can be replayed without reloading it.
// Optional build macro CL_NOTE_QUEUE_ERR_EN adds sticky o_err_overflow and
// o_err_badpitch flags for note words that are dropped during LOAD.
module cl_note_queue_bank #(
    parameter int NUM_CH = 37,
    parameter int DEPTH  = 16,
    parameter int TIME_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_write_en,
    input  logic [31:0]              i_write_word,
    input  logic                     i_restart,
    input  logic [NUM_CH-1:0]        i_metadata_request,
    output logic [NUM_CH-1:0]        o_metadata_available,
    output logic [NUM_CH*TIME_W-1:0] o_metadata_link,
    output logic [NUM_CH-1:0]        o_channel_done,
`ifdef CL_NOTE_QUEUE_ERR_EN
    output logic                     o_err_overflow,
    output logic                     o_err_badpitch,
`endif
    output logic                     o_loaded
);

    // Counters span 0..DEPTH inclusive; storage is indexed with the low bits
    // only, which is safe because a write/read only happens below DEPTH.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_LOAD, S_PLAY} state_t;

    state_t                          r_state, w_state_nxt;
    logic [TIME_W-1:0]               r_mem [NUM_CH][DEPTH];
    logic [CW-1:0]                   r_len [NUM_CH];
    logic [CW-1:0]                   r_rd  [NUM_CH];
    logic [NUM_CH-1:0]               r_avail;
    logic [NUM_CH-1:0][TIME_W-1:0]   r_link;
    logic [NUM_CH-1:0]               r_done;

    logic [2:0]        w_sys;
    logic [5:0]        w_pitch;
    logic [5:0]        w_pidx;
    logic              w_pitch_ok;
    logic              w_full;
    logic [TIME_W-1:0] w_time;
    logic              w_store, w_drop_full, w_drop_bad;
    logic [CW-1:0]     w_len_nxt [NUM_CH];
    logic [CW-1:0]     w_rd_nxt  [NUM_CH];
    logic [NUM_CH-1:0] w_pop;
    logic              w_unused;

    assign w_sys      = i_write_word[31:29];
    assign w_pitch    = i_write_word[28:23];
    assign w_time     = i_write_word[TIME_W-1:0];
    assign w_pitch_ok = ({26'd0, w_pitch} < NUM_CH);
    // Out-of-range pitches are steered to channel 0 so the lookup never
    // leaves the array; the word is dropped anyway.
    assign w_pidx     = w_pitch_ok ? w_pitch : 6'd0;
    assign w_full     = (r_len[w_pidx] == CW'(DEPTH));
    // String/fret fields are carried by the word format but unused here.
    assign w_unused   = ^{i_write_word[22:0], w_drop_full, w_drop_bad};

    assign o_metadata_available = r_avail;
    assign o_metadata_link      = r_link;
    assign o_channel_done       = r_done;
    assign o_loaded             = (r_state == S_PLAY);

    // State register: only reset returns to LOAD.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_LOAD;
        else         r_state <= w_state_nxt;
    end

    // Next state and load-word classification.
    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_drop_full = 1'b0;
        w_drop_bad  = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (i_write_en) begin
                    if (w_sys == 3'b000) begin
                        if (!w_pitch_ok)  w_drop_bad  = 1'b1;
                        else if (w_full)  w_drop_full = 1'b1;
                        else              w_store     = 1'b1;
                    end else if (w_sys == 3'b111) begin
                        w_state_nxt = S_PLAY;
                    end
                end
            end
            S_PLAY: ;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Per-channel next length/read index; restart beats a same-cycle request.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_len_nxt[c] = r_len[c];
            w_rd_nxt[c]  = r_rd[c];
            w_pop[c]     = 1'b0;
            if (w_store && (w_pidx == 6'(c)))
                w_len_nxt[c] = r_len[c] + CW'(1);
            if (r_state == S_PLAY) begin
                if (i_restart) begin
                    w_rd_nxt[c] = '0;
                end else if (i_metadata_request[c] && (r_rd[c] != r_len[c])) begin
                    w_pop[c]    = 1'b1;
                    w_rd_nxt[c] = r_rd[c] + CW'(1);
                end
            end
        end
    end

    // Note storage; contents are don't-care until len covers them, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_store)
            r_mem[w_pidx][r_len[w_pidx][IW-1:0]] <= w_time;
    end

    // Counters, pop results and the done level (empty after this cycle's update).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_len[c] <= '0;
                r_rd[c]  <= '0;
            end
            r_avail <= '0;
            r_link  <= '0;
            r_done  <= '1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_len[c]   <= w_len_nxt[c];
                r_rd[c]    <= w_rd_nxt[c];
                r_avail[c] <= w_pop[c];
                r_done[c]  <= (w_rd_nxt[c] == w_len_nxt[c]);
                // A request on an empty channel zeroes its slice; otherwise
                // the slice holds its last value.
                if ((r_state == S_PLAY) && !i_restart && i_metadata_request[c])
                    r_link[c] <= w_pop[c] ? r_mem[c][r_rd[c][IW-1:0]] : '0;
            end
        end
    end

`ifdef CL_NOTE_QUEUE_ERR_EN
    // Sticky drop flags, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_err_overflow <= 1'b0;
            o_err_badpitch <= 1'b0;
        end else begin
            if (w_drop_full) o_err_overflow <= 1'b1;
            if (w_drop_bad)  o_err_badpitch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cl_note_queue_bank.sv
// Bench for cl_note_queue_bank: table of vectors, directed corner sequences,
// and random traffic checked every cycle against a queue-based model.
module tb_cl_note_queue_bank;

    localparam int NUM_CH = 37;
    localparam int DEPTH  = 16;
    localparam int TIME_W = 16;
    localparam int LW     = NUM_CH * TIME_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              we = 1'b0;
    logic [31:0]       word = '0;
    logic              rs = 1'b0;
    logic [NUM_CH-1:0] req = '0;
    logic [NUM_CH-1:0] av;
    logic [LW-1:0]     link;
    logic [NUM_CH-1:0] done;
    logic              loaded;
`ifdef CL_NOTE_QUEUE_ERR_EN
    logic              err_of, err_bp;
`endif

    cl_note_queue_bank #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TIME_W(TIME_W)) dut (
        .i_clk(clk), .i_reset(rst), .i_write_en(we), .i_write_word(word),
        .i_restart(rs), .i_metadata_request(req),
        .o_metadata_available(av), .o_metadata_link(link),
        .o_channel_done(done),
`ifdef CL_NOTE_QUEUE_ERR_EN
        .o_err_overflow(err_of), .o_err_badpitch(err_bp),
`endif
        .o_loaded(loaded));

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    // Reference model: a list of notes per pitch plus a replay cursor.
    int unsigned                m_q [NUM_CH][$];
    int                         m_rd [NUM_CH];
    bit                         m_loaded;
    bit                         m_eof, m_ebp;
    logic [NUM_CH-1:0]          m_av, m_done;
    logic [NUM_CH-1:0][TIME_W-1:0] m_link;

    function automatic logic [31:0] mk(input int sys, input int pitch, input int tm);
        logic [31:0] w;
        w = '0;
        w[31:29] = sys[2:0];
        w[28:23] = pitch[5:0];
        w[15:0]  = tm[15:0];
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_q[c].delete();
            m_rd[c] = 0;
        end
        m_loaded = 0; m_eof = 0; m_ebp = 0;
        m_av = '0; m_link = '0; m_done = '1;
    endtask

    task automatic model_step(input bit w_en, input logic [31:0] w, input bit r, input logic [NUM_CH-1:0] q);
        int sys, p;
        sys = int'(w[31:29]);
        p   = int'(w[28:23]);
        m_av = '0;
        if (!m_loaded) begin
            if (w_en) begin
                if (sys == 0) begin
                    if (p >= NUM_CH)                 m_ebp = 1;
                    else if (m_q[p].size() >= DEPTH) m_eof = 1;
                    else                             m_q[p].push_back(int'(w[15:0]));
                end else if (sys == 7) begin
                    m_loaded = 1;
                end
            end
        end else if (r) begin
            for (int c = 0; c < NUM_CH; c++) m_rd[c] = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (q[c]) begin
                    if (m_rd[c] < m_q[c].size()) begin
                        m_link[c] = TIME_W'(m_q[c][m_rd[c]]);
                        m_rd[c]++;
                        m_av[c] = 1'b1;
                    end else begin
                        m_link[c] = '0;
                    end
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) m_done[c] = (m_rd[c] == m_q[c].size());
    endtask

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs after the edge.
    task automatic step(input bit r, input bit w_en, input logic [31:0] w, input bit rst_p,
                        input logic [NUM_CH-1:0] q);
        rst = r; we = w_en; word = w; rs = rst_p; req = q;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(w_en, w, rst_p, q);
        #1;
        chk("avail",  LW'(av),     LW'(m_av));
        chk("link",   link,        LW'(m_link));
        chk("done",   LW'(done),   LW'(m_done));
        chk("loaded", LW'(loaded), LW'(m_loaded));
`ifdef CL_NOTE_QUEUE_ERR_EN
        chk("err_overflow", LW'(err_of), LW'(m_eof));
        chk("err_badpitch", LW'(err_bp), LW'(m_ebp));
`endif
        rst = 0; we = 0; rs = 0; req = '0;
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, '0);
    endtask

    task automatic load(input int p, input int tm);
        step(0, 1, mk(0, p, tm), 0, '0);
    endtask

    task automatic pop(input logic [NUM_CH-1:0] q);
        step(0, 0, '0, 0, q);
    endtask

    function automatic logic [NUM_CH-1:0] bit1(input int c);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [TIME_W-1:0] slice(input int c);
        return link[c*TIME_W +: TIME_W];
    endfunction

    typedef struct {
        bit          we;
        logic [31:0] word;
        int          req_ch;
        int          ch;
        bit          e_av;
        int          e_link;
        bit          e_done;
        bit          e_ld;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, mk(0, 26, 300),  -1, 26, 1'b0, 0,    1'b0, 1'b0};
        tbl[1] = '{1'b1, mk(0, 26, 500),  -1, 26, 1'b0, 0,    1'b0, 1'b0};
        tbl[2] = '{1'b1, mk(0, 26, 1000), -1, 26, 1'b0, 0,    1'b0, 1'b0};
        tbl[3] = '{1'b0, 32'd0,           26, 26, 1'b0, 0,    1'b0, 1'b0};
        tbl[4] = '{1'b1, mk(7, 0, 0),     -1, 26, 1'b0, 0,    1'b0, 1'b1};
        tbl[5] = '{1'b0, 32'd0,           26, 26, 1'b1, 300,  1'b0, 1'b1};
        tbl[6] = '{1'b0, 32'd0,           26, 26, 1'b1, 500,  1'b0, 1'b1};
        tbl[7] = '{1'b0, 32'd0,           26, 26, 1'b1, 1000, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 32'd0,           26, 26, 1'b0, 0,    1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_avail",  LW'(av),     LW'(0));
        chk("rst_link",   link,        LW'(0));
        chk("rst_done",   LW'(done),   LW'({NUM_CH{1'b1}}));
        chk("rst_loaded", LW'(loaded), LW'(0));

        // Single pitch load/drain, including a request before the end marker
        for (int i = 0; i < 9; i++) begin
            logic [NUM_CH-1:0] q;
            q = (tbl[i].req_ch >= 0) ? bit1(tbl[i].req_ch) : '0;
            step(0, tbl[i].we, tbl[i].word, 0, q);
            chk($sformatf("tbl%0d_av", i),   LW'(av[tbl[i].ch]),    LW'(tbl[i].e_av));
            chk($sformatf("tbl%0d_link", i), LW'(slice(tbl[i].ch)), LW'(tbl[i].e_link));
            chk($sformatf("tbl%0d_done", i), LW'(done[tbl[i].ch]),  LW'(tbl[i].e_done));
            chk($sformatf("tbl%0d_ld", i),   LW'(loaded),           LW'(tbl[i].e_ld));
        end

        // Three channels popped in the same cycle
        do_reset();
        load(24, 400); load(26, 300); load(28, 200);
        step(0, 1, mk(7, 0, 0), 0, '0);
        pop(bit1(24) | bit1(26) | bit1(28));
        chk("multi_av",    LW'({av[24], av[26], av[28]}),       LW'(3'b111));
        chk("multi_l24",   LW'(slice(24)),                      LW'(400));
        chk("multi_l26",   LW'(slice(26)),                      LW'(300));
        chk("multi_l28",   LW'(slice(28)),                      LW'(200));
        chk("multi_done",  LW'({done[24], done[26], done[28]}), LW'(3'b111));

        // Overflow and bad pitch
        do_reset();
        for (int i = 0; i <= DEPTH; i++) load(5, 100 + i);
        load(40, 77);
        step(0, 1, mk(7, 0, 0), 0, '0);
`ifdef CL_NOTE_QUEUE_ERR_EN
        chk("err_of_set", LW'(err_of), LW'(1));
        chk("err_bp_set", LW'(err_bp), LW'(1));
`endif
        for (int i = 0; i < DEPTH; i++) pop(bit1(5));
        chk("ovf_last_link", LW'(slice(5)), LW'(100 + DEPTH - 1));
        chk("ovf_last_done", LW'(done[5]),  LW'(1));
        pop(bit1(5));
        chk("ovf_extra_av",  LW'(av[5]),    LW'(0));

        // Restart wins over a same-cycle request, then replay
        do_reset();
        load(31, 1500); load(31, 1600);
        step(0, 1, mk(7, 0, 0), 0, '0);
        pop(bit1(31)); pop(bit1(31));
        chk("drain_done31", LW'(done[31]), LW'(1));
        step(0, 0, '0, 1, bit1(31));
        chk("rs_av",    LW'(av),       LW'(0));
        chk("rs_done",  LW'(done[31]), LW'(0));
        pop(bit1(31));
        chk("replay_av",   LW'(av[31]),    LW'(1));
        chk("replay_link", LW'(slice(31)), LW'(1500));
        chk("replay_done", LW'(done[31]),  LW'(0));

        // Reset mid-load discards earlier notes
        do_reset();
        load(2, 99); load(9, 5);
        do_reset();
        load(2, 7);
        step(0, 1, mk(7, 0, 0), 0, '0);
        pop(bit1(2));
        chk("ml_link", LW'(slice(2)), LW'(7));
        pop(bit1(2) | bit1(9));
        chk("ml_gone", LW'({av[2], av[9]}), LW'(2'b00));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 120; i++) begin
            int sys;
            sys = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 6));
            step(0, $urandom_range(0, 4) != 0,
                 mk(sys, int'($urandom_range(0, 45)), int'($urandom)),
                 $urandom_range(0, 9) == 0, {NUM_CH{1'b1}});
        end
        step(0, 1, mk(7, 0, 0), 0, '0);
        for (int i = 0; i < 400; i++) begin
            logic [NUM_CH-1:0] q;
            for (int c = 0; c < NUM_CH; c++) q[c] = ($urandom_range(0, 3) == 0);
            step(0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 40) == 0, q);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
